// File: rtl/uart_pkg.sv
// Shared constants and types for the memory-mapped UART receiver.
package uart_pkg;

  // Word addresses in the peripheral region, compared on all 32 bits.
  localparam logic [31:0] AddrRxd = 32'h4000_001C;
  localparam logic [31:0] AddrCon = 32'h4000_0020;

  // CON register bit positions.
  localparam int unsigned ConValid = 0;
  localparam int unsigned ConFull  = 1;
  localparam int unsigned ConOvr   = 2;
  localparam int unsigned ConFe    = 3;
  localparam int unsigned ConIrqEn = 4;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } rx_state_e;

endpackage

// File: rtl/rx_fifo.sv
// Byte FIFO for received characters; a pop lets a push into a full FIFO succeed.
module rx_fifo #(
  parameter int unsigned Depth = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       empty,
  output logic       full,
  output logic       empty_next
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic [7:0]      mem_q [Depth];
  logic            pop_eff, push_eff;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CntW'(Depth));
  // Pop on empty is ignored; push on full only lands when a pop frees a slot.
  assign pop_eff  = pop & ~empty;
  assign push_eff = push & (~full | pop_eff);
  assign head     = mem_q[rd_ptr_q];

  // Occupancy after this edge.
  always_comb begin
    count_d = count_q;
    if (push_eff && !pop_eff) begin
      count_d = count_q + 1'b1;
    end else if (pop_eff && !push_eff) begin
      count_d = count_q - 1'b1;
    end
  end

  assign empty_next = (count_d == '0);

  // Pointer and count state; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_eff) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_eff)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage array, no reset needed since count gates visibility.
  always_ff @(posedge clk) begin
    if (push_eff) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/uart_rx_unit.sv
// 16x oversampling 8N1 UART receiver with FIFO, status register and level irq.
module uart_rx_unit
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_rx,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam int unsigned Div  = CLK_HZ / (BAUD * 16);
  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [CntW-1:0] DivMax = CntW'(Div - 1);

  rx_state_e       state_q, state_d;
  logic [CntW-1:0] baud_q, baud_d;
  logic [3:0]      tick_cnt_q, tick_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            sync1_q, sync2_q;
  logic            ovr_q, ovr_d, fe_q, fe_d, irq_en_q, irq_en_d, irq_q;
  logic            tick, push_req, fe_set, ovr_set;
  logic            rd_rxd, rd_con, wr_con;
  logic [7:0]      fifo_head;
  logic            fifo_empty, fifo_full, fifo_empty_next;
  logic            unused_wdata;

  assign unused_wdata = ^{wdata[31:5], wdata[1:0]};

  assign rd_rxd = mem_rd & (addr == AddrRxd);
  assign rd_con = mem_rd & (addr == AddrCon);
  assign wr_con = mem_wr & (addr == AddrCon);
  assign tick   = (baud_q == DivMax);

  // Receive FSM, baud/tick counters and shift register next state.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    push_req   = 1'b0;
    fe_set     = 1'b0;
    if (state_q == StIdle || state_q == StBreak || tick) begin
      baud_d = '0;
    end else begin
      baud_d = baud_q + 1'b1;
    end
    if (tick) tick_cnt_d = tick_cnt_q + 1'b1;
    unique case (state_q)
      StIdle: begin
        if (!sync2_q) begin
          state_d    = StStart;
          tick_cnt_d = '0;
        end
      end
      StStart: begin
        // Mid-start-bit check rejects glitches shorter than half a bit.
        if (tick && tick_cnt_q == 4'd7) begin
          tick_cnt_d = '0;
          if (!sync2_q) begin
            state_d   = StData;
            bit_idx_d = '0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StData: begin
        if (tick && tick_cnt_q == 4'd15) begin
          shift_d = {sync2_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      StStop: begin
        if (tick && tick_cnt_q == 4'd15) begin
          if (sync2_q) begin
            push_req = 1'b1;
            state_d  = StIdle;
          end else begin
            fe_set  = 1'b1;
            state_d = StBreak;
          end
        end
      end
      StBreak: begin
        if (sync2_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // A full FIFO with a same-edge RXD read accepts the byte, so no overrun then.
  assign ovr_set = push_req & fifo_full & ~rd_rxd;

  // Control register updates; a same-cycle set beats a write-1-to-clear.
  always_comb begin
    irq_en_d = irq_en_q;
    ovr_d    = ovr_q;
    fe_d     = fe_q;
    if (wr_con) begin
      irq_en_d = wdata[ConIrqEn];
      if (wdata[ConOvr]) ovr_d = 1'b0;
      if (wdata[ConFe])  fe_d  = 1'b0;
    end
    if (ovr_set) ovr_d = 1'b1;
    if (fe_set)  fe_d  = 1'b1;
  end

  // All sequential state, including the two-flop line synchronizer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      baud_q     <= '0;
      tick_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      ovr_q      <= 1'b0;
      fe_q       <= 1'b0;
      irq_en_q   <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      tick_cnt_q <= tick_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      sync1_q    <= uart_rx;
      sync2_q    <= sync1_q;
      ovr_q      <= ovr_d;
      fe_q       <= fe_d;
      irq_en_q   <= irq_en_d;
      irq_q      <= irq_en_d & ~fifo_empty_next;
    end
  end

  assign irq = irq_q;

  // Combinational read mux; RXD on an empty FIFO reads zero.
  always_comb begin
    rdata = '0;
    if (rd_rxd && !fifo_empty) begin
      rdata = {24'b0, fifo_head};
    end else if (rd_con) begin
      rdata[ConValid] = ~fifo_empty;
      rdata[ConFull]  = fifo_full;
      rdata[ConOvr]   = ovr_q;
      rdata[ConFe]    = fe_q;
      rdata[ConIrqEn] = irq_en_q;
    end
  end

  rx_fifo #(
    .Depth(FIFO_DEPTH)
  ) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_req),
    .push_data (shift_q),
    .pop       (rd_rxd),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .empty_next(fifo_empty_next)
  );

endmodule

// File: doc/uart_rx_unit.md
# uart_rx_unit

Memory-mapped UART receiver for the single-cycle MIPS system, sitting on the processor's data-memory bus beside the data memory. Oversamples the serial line at 16× baud, deframes 8N1 bytes into a small FIFO, and raises a level interrupt request that the processor's interrupt logic consumes. Software reads bytes and status through two word addresses in the peripheral region (0x4000_0000 and up).

## Interface
- `CLK_HZ`, 50_000_000: frequency of `clk`.
- `BAUD`, 9600: line rate. `DIV = CLK_HZ/(BAUD*16)`, truncated; must be ≥ 2.
- `FIFO_DEPTH`, 4: power of two, ≥ 2.
- `clk`  in  1: single clock, shared with the processor bus; all state changes on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `uart_rx`  in  1: asynchronous serial line, idle high.
- `mem_rd`  in  1: bus read strobe.
- `mem_wr`  in  1: bus write strobe.
- `addr`  in  32: byte address from the ALU result.
- `wdata`  in  32: write data.
- `rdata`  out  32: combinational read data; 0 unless `mem_rd` and a decoded address. The bus ORs this with other sources.
- `irq`  out  1: interrupt request, registered.

## Operation
- Address map: RXD = 0x4000_001C, CON = 0x4000_0020. The full 32-bit address is compared.
- RXD read: `rdata = {24'b0, head byte}`. A pop occurs at the edge only if the FIFO is non-empty. Reading RXD while empty returns 0 and changes nothing. Writes to RXD are ignored.
- CON read bits:
  - [0] valid (FIFO non-empty)
  - [1] full
  - [2] overrun (sticky)
  - [3] framing error (sticky)
  - [4] irq_en
  - others 0
- CON write:
  - [4] loads irq_en.
  - Writing 1 to [2] or [3] clears that flag (write-1-to-clear). If a flag is set and cleared in the same cycle, set wins.
- `irq` is registered as irq_en & (FIFO non-empty after this edge).
- Input path: 2-flop synchronizer. Both flops reset to 1.
- Baud counter: runs 0..DIV-1, held at 0 in IDLE. `tick` = (counter == DIV-1). A tick count runs 0..15 per bit.
- FSM:
  - IDLE: synced line = 0 → START, counters cleared.
  - START: at the 8th tick, sample. If 0 → DATA with bit index 0. If 1 → IDLE (glitch rejected).
  - DATA: every 16 ticks, sample into a shift register, LSB first. After bit 7 → STOP.
  - STOP: 16 ticks later, sample.
    - If 1: push the byte (or drop it and set overrun if the FIFO is full), then → IDLE.
    - If 0: set framing error, no push, → BREAK.
  - BREAK: wait for synced line = 1, then → IDLE.
- FIFO: push at the stop-sample edge; pop on RXD read.
  - Pop and push together when full: both succeed, count unchanged, no overrun.
  - Pop and push together when empty: only the push takes effect.
  - Pointers wrap modulo FIFO_DEPTH. Count width is log2(FIFO_DEPTH)+1.

## Timing
- Reset values: `irq` = 0, `rdata` = 0. FSM in IDLE, FIFO empty, both flags 0, irq_en = 0, synchronizer = 1.
- Reset mid-frame aborts the frame and flushes the FIFO. No byte is pushed.
- Line-to-synced latency: 2 cycles.
- Start detect to stop sample: 8 + 16×9 = 152 ticks = 152×DIV cycles.
- Push edge → CON[0] reads 1 on the next cycle; `irq` rises at that same edge if irq_en = 1.
- RXD read edge → head advances. `irq` falls at that edge if the FIFO becomes empty.
- `rdata` is valid in the same cycle as `mem_rd` (single-cycle CPU load).

## Structure
- Shared package `uart_pkg`:
  - RXD/CON address constants.
  - CON bit indices.
  - FSM state enum {IDLE, START, DATA, STOP, BREAK}.
- Sub-module `rx_fifo`:
  - Parameterized depth, width 8.
  - Ports: push / push_data / pop / head / empty / full.
  - The full-plus-simultaneous-pop rule lives here.

## Test plan
Bench parameters: CLK_HZ = 1_600_000, BAUD = 10_000, so DIV = 10 and one bit = 160 cycles.
- **Single byte:** send 0xA5 with CON = 0x10 → `irq` = 1 the cycle after the stop sample. CON read = 0x11. RXD read = 0x000000A5. Next cycle `irq` = 0 and CON = 0x10.
- **Glitch:** drive the line low for 40 cycles, then high → FSM returns to IDLE and the FIFO stays empty.
- **Overrun:** send 0x01..0x05 with no reads → FIFO holds 01..04, CON[1] = 1, CON[2] = 1. Four reads return 01, 02, 03, 04. Writing 0x04 to CON clears overrun.
- **Framing error:** send 0x3C with the stop bit = 0 → CON[3] = 1, no push. The FSM stays in BREAK until the line returns high. A following 0x55 is then received correctly.
- **Full with simultaneous read:** with the FIFO full, issue an RXD read on the same edge as the 5th stop sample → no overrun, count stays 4, order is preserved.
- **Reset mid-frame:** assert `reset` during DATA bit 3 → all outputs and flags return to reset values, and the next frame (0x7E) is received correctly.
